// File: rtl/alu_issue_if.sv
// Request/result handshake bundle between an upstream issuer and alu_issue_ctrl.
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic        out_wb;
    logic        out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_wb, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_flags, out_wb, out_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller: registers one ALU request, drives an external ALU for one
// cycle, then holds the result and the {O,C,N,Z} flag register for downstream.
//
// state | meaning
// IDLE  | no op in flight, ready for a request
// EXEC  | ALU driven from registered op/operands, result captured at the edge
// HOLD  | result valid, waiting for out_ready
module alu_issue_ctrl #(
    parameter bit SHIFT_MASK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.slave  io,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_opcode,
    output logic        alu_sub,
    output logic        alu_cin,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_status
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ADC  = 4'd2;
    localparam logic [3:0] OP_CMP  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_CLRF = 4'd10;

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] result_q, result_d;
    logic [3:0]  flags_q, flags_d;
    logic        wb_q, wb_d;
    logic        err_q, err_d;
    logic        valid_q, valid_d;

    logic        in_ready_w;
    logic        accept;
    logic [2:0]  dec_opcode;
    logic        dec_sub, dec_cin;
    logic        dec_arith, dec_logic, dec_clrf, dec_legal;

    assign in_ready_w    = rst_n && ((state_q == IDLE) || ((state_q == HOLD) && io.out_ready));
    assign accept        = io.in_valid && in_ready_w;
    assign io.in_ready   = in_ready_w;
    assign io.out_valid  = valid_q;
    assign io.out_result = result_q;
    assign io.out_flags  = flags_q;
    assign io.out_wb     = wb_q;
    assign io.out_err    = err_q;

    // ADC reads flags_q, which already holds the previous op's update.
    always_comb begin
        dec_opcode = 3'b000;
        dec_sub    = 1'b0;
        dec_cin    = 1'b0;
        dec_arith  = 1'b0;
        dec_logic  = 1'b0;
        dec_clrf   = 1'b0;
        case (op_q)
            OP_ADD:         dec_arith = 1'b1;
            OP_SUB, OP_CMP: begin dec_arith = 1'b1; dec_sub = 1'b1; end
            OP_ADC:         begin dec_arith = 1'b1; dec_cin = flags_q[2]; end
            OP_XOR:         begin dec_logic = 1'b1; dec_opcode = 3'b001; end
            OP_AND:         begin dec_logic = 1'b1; dec_opcode = 3'b010; end
            OP_OR:          begin dec_logic = 1'b1; dec_opcode = 3'b011; end
            OP_NOR:         begin dec_logic = 1'b1; dec_opcode = 3'b100; end
            OP_SLL:         begin dec_logic = 1'b1; dec_opcode = 3'b101; end
            OP_SRA:         begin dec_logic = 1'b1; dec_opcode = 3'b110; end
            OP_CLRF:        begin dec_clrf  = 1'b1; dec_opcode = 3'b111; end
            default:        dec_opcode = 3'b000;
        endcase
        dec_legal = dec_arith || dec_logic || dec_clrf;
    end

    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = '0;
        alu_sub    = 1'b0;
        alu_cin    = 1'b0;
        if ((state_q == EXEC) && dec_legal) begin
            alu_a      = a_q;
            alu_b      = b_q;
            alu_opcode = dec_opcode;
            alu_sub    = dec_sub;
            alu_cin    = dec_cin;
            if (SHIFT_MASK && ((op_q == OP_SLL) || (op_q == OP_SRA))) begin
                alu_b = {27'd0, b_q[4:0]};
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        flags_d  = flags_q;
        wb_d     = wb_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = EXEC;
            end
            EXEC: begin
                state_d  = HOLD;
                err_d    = !dec_legal;
                wb_d     = (dec_arith && (op_q != OP_CMP)) || dec_logic;
                result_d = (dec_arith || dec_logic) ? alu_result : 32'd0;
                if (dec_arith)      flags_d = alu_status;
                else if (dec_logic) flags_d = {flags_q[3:2], alu_status[1:0]};
                else if (dec_clrf)  flags_d = 4'b0000;
            end
            HOLD: begin
                if (io.out_ready) state_d = io.in_valid ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            op_d = io.in_op;
            a_d  = io.in_a;
            b_d  = io.in_b;
        end
        valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            wb_q     <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            wb_q     <= wb_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on the ALU ports, transaction-level
// reference model checked every cycle, directed cases plus randomized traffic.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if io();

    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_opcode;
    logic        alu_sub, alu_cin;
    logic [3:0]  alu_status;

    alu_issue_ctrl #(.SHIFT_MASK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .io(io),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_sub(alu_sub), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_status(alu_status)
    );

    // Behavioural ALU attached to the DUT's ALU ports.
    logic [31:0] tb_bx;
    logic [32:0] tb_s;
    always_comb begin
        tb_bx      = '0;
        tb_s       = '0;
        alu_result = '0;
        alu_status = '0;
        case (alu_opcode)
            3'b000: begin
                tb_bx = alu_sub ? ~alu_b : alu_b;
                tb_s  = {1'b0, alu_a} + {1'b0, tb_bx} + {32'd0, (alu_sub | alu_cin)};
                alu_result    = tb_s[31:0];
                alu_status[3] = (alu_a[31] == tb_bx[31]) && (tb_s[31] != alu_a[31]);
                alu_status[2] = tb_s[32];
            end
            3'b001: alu_result = alu_a ^ alu_b;
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = ~(alu_a | alu_b);
            3'b101: alu_result = alu_a << alu_b[4:0];
            3'b110: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            default: alu_result = '0;
        endcase
        alu_status[1] = alu_result[31];
        alu_status[0] = (alu_result == 32'd0);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Architectural result of one op, from plain arithmetic.
    function automatic void ref_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] fl, output logic [31:0] r, output logic wb,
                                     output logic err, output logic [3:0] nf);
        logic [32:0] s;
        logic signed [31:0] sa;
        s = '0; sa = a; r = '0; wb = 1'b0; err = 1'b0; nf = fl;
        case (op)
            4'd0, 4'd2: begin
                s  = {1'b0, a} + {1'b0, b} + ((op == 4'd2) ? {32'd0, fl[2]} : 33'd0);
                r  = s[31:0];
                nf = {(a[31] == b[31]) && (r[31] != a[31]), s[32], r[31], r == 32'd0};
                wb = 1'b1;
            end
            4'd1, 4'd3: begin
                r  = a - b;
                nf = {(a[31] != b[31]) && (r[31] != a[31]), a >= b, r[31], r == 32'd0};
                wb = (op == 4'd1);
            end
            4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
                case (op)
                    4'd4:    r = a ^ b;
                    4'd5:    r = a & b;
                    4'd6:    r = a | b;
                    4'd7:    r = ~(a | b);
                    4'd8:    r = a << b[4:0];
                    default: r = $unsigned(sa >>> b[4:0]);
                endcase
                nf = {fl[3:2], r[31], r == 32'd0};
                wb = 1'b1;
            end
            4'd10: nf = 4'b0000;
            default: err = 1'b1;
        endcase
    endfunction

    function automatic logic [4:0] ref_alu_ctl(input logic [3:0] op, input logic [3:0] fl);
        case (op)
            4'd0:       return 5'b000_0_0;
            4'd1, 4'd3: return 5'b000_1_0;
            4'd2:       return {4'b000_0, fl[2]};
            4'd4:       return 5'b001_0_0;
            4'd5:       return 5'b010_0_0;
            4'd6:       return 5'b011_0_0;
            4'd7:       return 5'b100_0_0;
            4'd8:       return 5'b101_0_0;
            4'd9:       return 5'b110_0_0;
            default:    return 5'b111_0_0;
        endcase
    endfunction

    bit          m_exec = 1'b0;
    bit          m_hold = 1'b0;
    logic [3:0]  m_op = '0;
    logic [31:0] m_a = '0, m_b = '0, m_res = '0;
    logic [3:0]  m_flags = '0;
    logic        m_wb = 1'b0, m_err = 1'b0;

    task automatic cycle(input bit v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit ordy, input bit rstn);
        bit exp_rdy, acc;
        @(negedge clk);
        rst_n = rstn;
        io.in_valid = v; io.in_op = op; io.in_a = a; io.in_b = b; io.out_ready = ordy;
        if (!rstn) begin m_exec = 1'b0; m_hold = 1'b0; m_flags = 4'b0000; end
        #1;
        exp_rdy = rstn && !m_exec && (!m_hold || ordy);
        acc     = v && exp_rdy;
        chk("in_ready", {31'd0, io.in_ready}, {31'd0, exp_rdy});
        chk("out_valid", {31'd0, io.out_valid}, {31'd0, m_hold});
        chk("out_flags", {28'd0, io.out_flags}, {28'd0, m_flags});
        if (m_hold) begin
            chk("out_result", io.out_result, m_res);
            chk("out_wb", {31'd0, io.out_wb}, {31'd0, m_wb});
            chk("out_err", {31'd0, io.out_err}, {31'd0, m_err});
        end
        if (m_exec) begin
            if (m_op <= 4'd10)
                chk("alu_ctl", {27'd0, alu_opcode, alu_sub, alu_cin}, {27'd0, ref_alu_ctl(m_op, m_flags)});
            if (m_op <= 4'd9) begin
                chk("alu_a", alu_a, m_a);
                chk("alu_b", alu_b, (m_op >= 4'd8) ? (m_b & 32'h1f) : m_b);
            end
        end else if (!acc) begin
            chk("alu_a_quiet", alu_a, 32'd0);
            chk("alu_b_quiet", alu_b, 32'd0);
            chk("alu_ctl_quiet", {27'd0, alu_opcode, alu_sub, alu_cin}, 32'd0);
        end
        if (rstn) begin
            if (m_exec) begin
                ref_exec(m_op, m_a, m_b, m_flags, m_res, m_wb, m_err, m_flags);
                m_exec = 1'b0;
                m_hold = 1'b1;
            end else if (m_hold && ordy) begin
                m_hold = 1'b0;
            end
            if (acc) begin
                m_op = op; m_a = a; m_b = b; m_exec = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom % 5)
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        io.in_valid = 1'b0; io.in_op = '0; io.in_a = '0; io.in_b = '0; io.out_ready = 1'b0;

        cycle(0, 0, 0, 0, 0, 0);
        chk("lit_rst_in_ready", {31'd0, io.in_ready}, 32'd0);
        chk("lit_rst_out_result", io.out_result, 32'd0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 1);
        chk("lit_idle_in_ready", {31'd0, io.in_ready}, 32'd1);

        cycle(1, 4'd0, 32'hFFFF_FFFF, 32'd1, 1, 1);
        cycle(0, 0, 0, 0, 1, 1);
        chk("lit_add_alu_b", alu_b, 32'd1);
        cycle(1, 4'd2, 32'd0, 32'd0, 1, 1);
        chk("lit_add_result", io.out_result, 32'd0);
        chk("lit_add_flags", {28'd0, io.out_flags}, 32'b0101);
        cycle(0, 0, 0, 0, 1, 1);
        chk("lit_adc_cin", {31'd0, alu_cin}, 32'd1);
        cycle(1, 4'd3, 32'd3, 32'd7, 1, 1);
        chk("lit_adc_result", io.out_result, 32'd1);
        cycle(0, 0, 0, 0, 1, 1);
        cycle(1, 4'd1, 32'd5, 32'd5, 1, 1);
        chk("lit_cmp_flags", {28'd0, io.out_flags}, 32'b0010);
        chk("lit_cmp_wb", {31'd0, io.out_wb}, 32'd0);
        cycle(0, 0, 0, 0, 1, 1);
        chk("lit_sub_alu_sub", {31'd0, alu_sub}, 32'd1);
        cycle(1, 4'd8, 32'd1, 32'h24, 1, 1);
        chk("lit_sub_result", io.out_result, 32'd0);
        chk("lit_sub_flags", {28'd0, io.out_flags}, 32'b0101);
        chk("lit_sub_wb", {31'd0, io.out_wb}, 32'd1);
        cycle(0, 0, 0, 0, 1, 1);
        chk("lit_sll_alu_b", alu_b, 32'd4);
        cycle(0, 0, 0, 0, 0, 1);
        chk("lit_sll_result", io.out_result, 32'h10);
        chk("lit_sll_flags", {28'd0, io.out_flags}, 32'b0100);
        for (int i = 0; i < 2; i++) begin
            cycle(1, 4'b1100, 32'd9, 32'd9, 0, 1);
            chk("lit_stall_in_ready", {31'd0, io.in_ready}, 32'd0);
            chk("lit_stall_result", io.out_result, 32'h10);
        end
        cycle(1, 4'b1100, 32'd9, 32'd9, 1, 1);
        chk("lit_xfer_in_ready", {31'd0, io.in_ready}, 32'd1);
        cycle(0, 0, 0, 0, 1, 1);
        cycle(1, 4'd10, 32'd0, 32'd0, 1, 1);
        chk("lit_ill_err", {31'd0, io.out_err}, 32'd1);
        chk("lit_ill_result", io.out_result, 32'd0);
        chk("lit_ill_flags", {28'd0, io.out_flags}, 32'b0100);
        cycle(0, 0, 0, 0, 1, 1);
        cycle(1, 4'd1, 32'd5, 32'd5, 1, 1);
        chk("lit_clrf_flags", {28'd0, io.out_flags}, 32'd0);
        cycle(0, 0, 0, 0, 1, 1);
        cycle(1, 4'd0, 32'd7, 32'd8, 1, 1);
        cycle(0, 0, 0, 0, 1, 0);
        chk("lit_rst_exec_flags", {28'd0, io.out_flags}, 32'd0);
        chk("lit_rst_exec_result", io.out_result, 32'd0);
        chk("lit_rst_exec_valid", {31'd0, io.out_valid}, 32'd0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 1);
        cycle(1, 4'd1, 32'd10, 32'd3, 1, 1);
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1, 1);
        chk("lit_post_rst_result", io.out_result, 32'd7);

        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom % 4) != 0, 4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
                  ($urandom % 3) != 0, ($urandom % 150) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
